rtc_snapshot_writer: RTL
========================

# rtc_snapshot_writer

Parametrised successor to the fixed six-field BCD-to-memory writer. On each time-update tick it captures a coherent snapshot of NUM_FIELDS packed BCD fields. It then writes them to the register-file memory through a ready/valid write port, either all fields or only the fields that changed. It sits between the RTC counter chain and the time register memory, and buffers one pending tick while a write sweep is in progress.

## Interface
- NUM_FIELDS, 6, number of fields (1..16); field i occupies fields_in[i*DATA_W +: DATA_W], field 0 = seconds
- DATA_W, 8, width of each field and of mem_data
- ADDR_W, 4, memory address width
- BASE_ADDR, 0, memory address of field 0
- clk  input  1  single clock; all state changes on rising edge
- rst_n  input  1  reset, asynchronous, active-low
- fields_in  input  NUM_FIELDS*DATA_W  live BCD time fields
- tick  input  1  one-cycle pulse: fields_in holds a new valid time
- mode  input  1  0 = write all fields, 1 = write changed fields only; sampled at capture
- mem_addr  output  ADDR_W  write address
- mem_data  output  DATA_W  write data
- mem_we  output  1  write request (valid)
- mem_ready  input  1  memory accepts; a transfer occurs on any cycle with mem_we && mem_ready
- busy  output  1  sweep in progress (state != IDLE)
- done  output  1  one-cycle pulse after a sweep completes
- overrun  output  1  sticky: a tick was lost
- clr_ovr  input  1  synchronous clear of overrun

## Operation
- State machine: IDLE, SCAN, WAIT, DONE.
- IDLE:
  - On tick, or on pending set, capture fields_in into the snapshot register and latch mode.
  - Compute dirty[i]. In mode 0, dirty[i] = 1. In mode 1, dirty[i] = !seen[i] || snap[i] != last[i].
  - Set idx = 0, clear pending, go to SCAN.
- SCAN, one index per cycle:
  - If dirty[idx] = 1, assert mem_we with mem_addr = BASE_ADDR + idx (mod 2^ADDR_W) and mem_data = snap[idx], then go to WAIT.
  - Otherwise keep mem_we = 0 and advance idx. After idx = NUM_FIELDS-1, go to DONE.
- WAIT:
  - Hold mem_we, mem_addr and mem_data stable until mem_ready = 1.
  - On transfer: set last[idx] = snap[idx], set seen[idx] = 1, and advance idx.
  - Then drop mem_we and return to SCAN, or go to DONE if idx was NUM_FIELDS-1.
- DONE: assert done for one cycle, then go to IDLE.
- Ticks while busy:
  - A tick with pending = 0 sets pending.
  - A tick with pending = 1 sets overrun, and the tick is dropped.
  - A pending capture uses fields_in at recapture time, not at tick time.
- overrun set has priority over clr_ovr in the same cycle.
- Snapshot is stable for the whole sweep; changes on fields_in mid-sweep never reach memory.
- Address arithmetic wraps modulo 2^ADDR_W. BASE_ADDR + NUM_FIELDS > 2^ADDR_W wraps silently.

## Timing
- Reset (async assert, synchronous-to-clk deassert handled upstream):
  - State IDLE; mem_we, mem_addr, mem_data, busy, done, overrun, pending all 0.
  - snap and last cleared to 0; seen cleared.
  - mem_we drops immediately on rst_n low; a partial sweep is abandoned with no further writes.
- Tick sampled at edge E: busy = 1 and first SCAN cycle after E.
- First mem_we assertion is after E+1 at the earliest; no write ever happens in the tick cycle.
- Sweep cost with mem_ready tied high:
  - Each dirty field costs 2 cycles (SCAN + WAIT); each clean field costs 1 cycle.
  - done pulses 1 cycle after the last index is retired.
  - busy falls the cycle after done.
- Pending recapture occurs in the IDLE cycle following DONE. Back-to-back sweeps have one IDLE cycle between them.
- mem_we is never asserted outside WAIT. At most one transfer per dirty field per sweep.

## Test plan
- Defaults, mode 0, mem_ready = 1, fields {yr 0x21, mon 0x02, day 0x07, hr 0x12, min 0x45, sec 0x32}, single tick -> six writes in order: addr 0..5 with data 0x32, 0x45, 0x12, 0x07, 0x02, 0x21; done at E+13.
- Mode 1, sec changes 0x32 -> 0x33 only, tick -> exactly one write (addr 0, data 0x33); done after 7 cycles.
- First tick after reset in mode 1 -> all six fields written (seen clear).
- mem_ready low for 3 cycles on the addr 2 write -> mem_addr and mem_data held stable; exactly one transfer; later fields unaffected.
- Two ticks during a sweep, with fields_in changed before recapture:
  - Second tick -> pending; the following sweep writes the recaptured values.
  - Third tick -> overrun = 1, held until clr_ovr.
- rst_n low while in WAIT on addr 3 -> mem_we = 0 immediately, all outputs 0; next tick in mode 1 rewrites all fields.

Source files
------------

// File: rtl/rtc_snapshot_writer_if.sv
// Memory write port of the RTC snapshot writer.
// Handshake: mem_we is the valid; a word transfers on every rising edge
// where mem_we && mem_ready. While mem_we is high and mem_ready is low, the
// master holds mem_addr and mem_data stable. The master never withdraws a
// request before it transfers, except under reset.
interface rtc_snapshot_writer_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data;
    logic              mem_we;
    logic              mem_ready;

    // Snapshot writer side: drives the request and samples the acceptance.
    modport master (
        output mem_addr,
        output mem_data,
        output mem_we,
        input  mem_ready
    );

    // Register-file memory side.
    modport slave (
        input  mem_addr,
        input  mem_data,
        input  mem_we,
        output mem_ready
    );
endinterface

// File: rtl/rtc_snapshot_writer.sv
// RTC snapshot writer.
// On each tick it captures a coherent snapshot of NUM_FIELDS packed BCD
// fields. It then sweeps them into the time register memory over the write
// port, writing either every field or only the fields whose value differs
// from the value last written. One tick that arrives mid-sweep is held as
// pending and recaptured after the sweep. A further tick is dropped and
// flagged in the sticky overrun bit.
module rtc_snapshot_writer #(
    parameter int NUM_FIELDS = 6,
    parameter int DATA_W     = 8,
    parameter int ADDR_W     = 4,
    parameter int BASE_ADDR  = 0
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [NUM_FIELDS*DATA_W-1:0] fields_in,
    input  logic                         tick,
    input  logic                         mode,
    rtc_snapshot_writer_if.master        mem,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun,
    input  logic                         clr_ovr,
    output logic [1:0]                   state_dbg
);

    localparam int IDX_W = (NUM_FIELDS > 1) ? $clog2(NUM_FIELDS) : 1;
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(NUM_FIELDS - 1);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [IDX_W-1:0]  idx;
    logic              pending;
    logic              overrun_q;
    logic [DATA_W-1:0] snap [NUM_FIELDS];
    logic [DATA_W-1:0] last [NUM_FIELDS];
    logic [NUM_FIELDS-1:0] seen;
    logic [NUM_FIELDS-1:0] dirty;

    logic capture;
    logic xfer;
    logic at_last;
    logic in_sweep;

    // A capture happens only from IDLE. A pending tick is taken here even
    // when no new tick is present.
    assign capture  = (state == IDLE) && (tick || pending);
    assign xfer     = (state == WAIT) && mem.mem_ready;
    assign at_last  = (idx == LAST_IDX);
    assign in_sweep = (state != IDLE);

    // State register; reset abandons any sweep in progress.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: one index per SCAN cycle, WAIT holds until accepted.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (capture) begin
                    state_nxt = SCAN;
                end
            end
            SCAN: begin
                if (dirty[idx]) begin
                    state_nxt = WAIT;
                end else if (at_last) begin
                    state_nxt = DONE;
                end else begin
                    state_nxt = SCAN;
                end
            end
            WAIT: begin
                if (mem.mem_ready) begin
                    state_nxt = at_last ? DONE : SCAN;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Field index: restarts at capture, advances past clean or retired fields.
    // It stops at the last field rather than wrapping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (capture) begin
            idx <= '0;
        end else if ((state == SCAN) && !dirty[idx] && !at_last) begin
            idx <= idx + 1'b1;
        end else if (xfer && !at_last) begin
            idx <= idx + 1'b1;
        end
    end

    // Snapshot and dirty mask are taken together at capture. They stay
    // frozen for the whole sweep, so later fields_in changes cannot leak
    // into memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                snap[i] <= '0;
            end
            dirty <= '0;
        end else if (capture) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                snap[i]  <= fields_in[i*DATA_W +: DATA_W];
                dirty[i] <= !mode || !seen[i] ||
                            (fields_in[i*DATA_W +: DATA_W] != last[i]);
            end
        end
    end

    // Record what memory now holds, and only on an accepted transfer.
    // An abandoned write therefore still counts as unwritten.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FIELDS; i++) begin
                last[i] <= '0;
            end
            seen <= '0;
        end else if (xfer) begin
            last[idx] <= snap[idx];
            seen[idx] <= 1'b1;
        end
    end

    // One-deep tick buffer. It is consumed by the capture in IDLE and armed
    // by a tick that arrives while a sweep is running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= 1'b0;
        end else if (capture) begin
            pending <= 1'b0;
        end else if (in_sweep && tick && !pending) begin
            pending <= 1'b1;
        end
    end

    // Sticky overrun: a tick lost to a full buffer wins over a clear in the
    // same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_q <= 1'b0;
        end else if (in_sweep && tick && pending) begin
            overrun_q <= 1'b1;
        end else if (clr_ovr) begin
            overrun_q <= 1'b0;
        end
    end

    // Outputs decoded from state. The write port is driven only in WAIT and
    // reads as zero elsewhere, so reset clears the request immediately.
    always_comb begin
        mem.mem_we   = 1'b0;
        mem.mem_addr = '0;
        mem.mem_data = '0;
        if (state == WAIT) begin
            mem.mem_we   = 1'b1;
            mem.mem_addr = BASE + ADDR_W'(idx);
            mem.mem_data = snap[idx];
        end
    end

    assign busy      = in_sweep;
    assign done      = (state == DONE);
    assign overrun   = overrun_q;
    assign state_dbg = state;

endmodule
